// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALUControl encodings, FSM state type and width default
//            for the iterative execute-stage ALU.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_XLEN = 32;

  // Encodings must match the ALU decoder bit-for-bit.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_ops.sv
`default_nettype none
// ============================================================================
// Module   : alu_comb_ops
// Purpose  : Single-cycle ALU operations; shifts and undefined codes give 0.
// Revision : 1.0
// ============================================================================
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    unique case (alu_control)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_iter_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_exec
// Purpose  : Execute-stage ALU with valid/ready handshakes; logic ops finish
//            in one cycle, shifts iterate one bit per cycle.
// Revision : 1.0
// ============================================================================
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;

  logic [XLEN-1:0]   comb_result;
  logic [XLEN-1:0]   shift_step;
  logic [SHW-1:0]    shamt_in;
  logic              accept;
  logic              start_shift;
  logic              shifting;

  alu_comb_ops #(.XLEN(XLEN)) u_comb_ops (
    .alu_control (ALUControl),
    .src_a       (SrcA),
    .src_b       (SrcB),
    .result      (comb_result)
  );

  assign shamt_in    = SrcB[SHW-1:0];
  assign accept      = in_valid & in_ready;
  assign start_shift = is_shift_op(ALUControl) && (shamt_in != '0);
  assign shifting    = (state_q == ST_SHIFT) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept)         state_d = start_shift ? ST_SHIFT : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // SRA re-reads the working MSB each step so sign fill accumulates.
  always_comb begin
    shift_step = result_q;
    unique case (op_q)
      ALU_SLL: shift_step = {result_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_step = {1'b0, result_q[XLEN-1:1]};
      ALU_SRA: shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: shift_step = result_q;
    endcase
  end

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    if (accept) begin
      op_d = ALUControl;
      if (is_shift_op(ALUControl)) begin
        result_d = SrcA;
        cnt_d    = shamt_in;
      end else begin
        result_d = comb_result;
        cnt_d    = '0;
      end
      zero_d = (result_d == '0);
    end else if (shifting) begin
      result_d = shift_step;
      cnt_d    = cnt_q - SHW'(1);
      zero_d   = (result_d == '0);
    end
  end

  always_comb begin
    in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    out_valid = (state_q == ST_DONE);
    ALUResult = result_q;
    Zero      = zero_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter_exec
// Purpose  : Directed self-checking bench for alu_iter_exec.
// Revision : 1.0
// ============================================================================
module tb_alu_iter_exec;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ALUControl;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALUResult;
  logic            Zero;

  int n_checks;
  int n_errors;

  alu_iter_exec #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, scramble inputs after accept, wait for the result
  // and consume it; extra = edges between accept and first out_valid.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_zero, input int exp_extra);
    int extra;
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    out_ready  = 1'b1;
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid   = 1'b0;
    ALUControl = 4'b0000;
    SrcA       = 32'hDEAD_BEEF;
    SrcB       = 32'h0000_0003;
    extra = 0;
    while (!out_valid && extra < 100) begin
      tick();
      extra++;
    end
    check_val({tag, "_latency"}, 32'(extra), 32'(exp_extra));
    check_val({tag, "_result"}, ALUResult, exp_res);
    check_val({tag, "_zero"}, 32'(Zero), 32'(exp_zero));
    tick();
    check_val({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    ALUControl = 4'b0000;
    SrcA       = '0;
    SrcB       = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result", ALUResult, 32'd0);
    check_val("rst_zero", 32'(Zero), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    do_op("sub",   4'b0001, 32'd5,          32'd5,          32'h0000_0000, 1'b1, 0);
    do_op("add",   4'b0000, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 0);
    do_op("slt",   4'b0101, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0, 0);
    do_op("sltu",  4'b0110, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 1'b1, 0);
    do_op("undef", 4'b1100, 32'h1234_5678,  32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 0);
    do_op("and",   4'b0010, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 1'b0, 0);
    do_op("sra",   4'b1001, 32'h8000_0000,  32'd4,          32'hF800_0000, 1'b0, 4);
    do_op("srl",   4'b1000, 32'h8000_0000,  32'd4,          32'h0800_0000, 1'b0, 4);
    do_op("sll31", 4'b0111, 32'h0000_0001,  32'd31,         32'h8000_0000, 1'b0, 31);
    do_op("sll0",  4'b0111, 32'h0000_1234,  32'd0,          32'h0000_1234, 1'b0, 0);
    do_op("srlhi", 4'b1000, 32'h8000_0000,  32'h0000_0025, 32'h0400_0000, 1'b0, 5);
    do_op("sra+",  4'b1001, 32'h4000_0000,  32'd2,          32'h1000_0000, 1'b0, 2);

    // Back-to-back single-cycle ops with consumer always ready.
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    ALUControl = 4'b0000; SrcA = 32'd1;  SrcB = 32'd2;
    check_val("b2b_rdy0", 32'(in_ready), 32'd1);
    tick();
    check_val("b2b_v0", 32'(out_valid), 32'd1);
    check_val("b2b_r0", ALUResult, 32'd3);
    ALUControl = 4'b0100; SrcA = 32'h0F; SrcB = 32'h03;
    check_val("b2b_rdy1", 32'(in_ready), 32'd1);
    tick();
    check_val("b2b_v1", 32'(out_valid), 32'd1);
    check_val("b2b_r1", ALUResult, 32'h0C);
    ALUControl = 4'b0011; SrcA = 32'h10; SrcB = 32'h01;
    check_val("b2b_rdy2", 32'(in_ready), 32'd1);
    tick();
    check_val("b2b_v2", 32'(out_valid), 32'd1);
    check_val("b2b_r2", ALUResult, 32'h11);

    // Backpressure: result holds, new request ignored.
    out_ready  = 1'b0;
    ALUControl = 4'b0000; SrcA = 32'd100; SrcB = 32'd100;
    #1;
    check_val("bp_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bp_valid", 32'(out_valid), 32'd1);
      check_val("bp_result", ALUResult, 32'h11);
      check_val("bp_rdy_hold", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("bp_drain", 32'(out_valid), 32'd0);

    // Flush on the third cycle of a 10-step shift.
    in_valid   = 1'b1;
    ALUControl = 4'b0111; SrcA = 32'd1; SrcB = 32'd10;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check_val("fl_rdy_low", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_val("fl_valid", 32'(out_valid), 32'd0);
    check_val("fl_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("fl_quiet", 32'(out_valid), 32'd0);
    end
    do_op("fl_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 0);

    // Reset in the middle of a shift.
    in_valid   = 1'b1;
    ALUControl = 4'b0111; SrcA = 32'd1; SrcB = 32'd10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_val("rs_shift_valid", 32'(out_valid), 32'd0);
    check_val("rs_shift_result", ALUResult, 32'd0);
    check_val("rs_shift_zero", 32'(Zero), 32'd0);
    check_val("rs_shift_rdy", 32'(in_ready), 32'd1);

    // Reset while holding a result in DONE.
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    ALUControl = 4'b0000; SrcA = 32'd7; SrcB = 32'd8;
    tick();
    in_valid = 1'b0;
    check_val("rs_done_valid_pre", 32'(out_valid), 32'd1);
    check_val("rs_done_result_pre", ALUResult, 32'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_val("rs_done_valid", 32'(out_valid), 32'd0);
    check_val("rs_done_result", ALUResult, 32'd0);
    check_val("rs_done_zero", 32'(Zero), 32'd0);
    check_val("rs_done_rdy", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
